// File: rtl/v_hier_sched_if.sv
// Bus between v_hier_sched and its four requesters plus the shared lane datapath.
// slave  : the scheduler's side (consumes requests and lane result, drives grant/operand/response).
// master : the surrounding environment (requesters and lane datapath).
interface v_hier_sched_if;
  logic [3:0]  req;
  logic [15:0] req_avec;
  logic [3:0]  gnt;
  logic [3:0]  avec;
  logic        avec_vld;
  logic [3:0]  qvec;
  logic [3:0]  resp_q;
  logic        resp_vld;
  logic        busy;

  modport slave (
    input  req, req_avec, qvec,
    output gnt, avec, avec_vld, resp_q, resp_vld, busy
  );

  modport master (
    output req, req_avec, qvec,
    input  gnt, avec, avec_vld, resp_q, resp_vld, busy
  );
endinterface

// File: rtl/v_hier_sched.sv
// v_hier_sched: round-robin scheduler sharing one lane datapath among four
// requesters. IDLE arbitrates, GRANT drives the winner's operand to the lane,
// RELEASE inserts one dead cycle before the next arbitration. The lane result
// comes back through a fixed one-cycle response register.
// Optional feature: define V_HIER_SCHED_TIMEOUT_EN to force a release after
// MAX_HOLD consecutive GRANT cycles.
module v_hier_sched #(
  parameter int unsigned MAX_HOLD = 8
) (
  input logic           clk,
  input logic           reset_l,
  v_hier_sched_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
`ifdef V_HIER_SCHED_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_gnt;
  logic [1:0]  r_last_winner;
  logic [7:0]  r_hold_cnt;
  logic [3:0]  r_resp_q_p1;
  logic        r_resp_vld_p1;

  logic [1:0]  w_winner;
  logic        w_any_req;
  logic        w_timeout;
  logic        w_release;
  logic [3:0]  w_avec;
  logic        w_avec_vld;
  logic        w_busy;

  // Round-robin search: the requester right after last_winner has top priority,
  // last_winner itself has the lowest; 2-bit index arithmetic wraps 3 -> 0.
  always_comb begin
    w_winner  = r_last_winner;
    w_any_req = |bus.req;
    for (int k = 4; k >= 1; k--) begin
      if (bus.req[r_last_winner + 2'(k)]) begin
        w_winner = r_last_winner + 2'(k);
      end
    end
  end

  // A grant ends when its owner drops req, or when the hold limit is reached.
  always_comb begin
    w_timeout = TIMEOUT_EN && (r_hold_cnt == HOLD_LAST);
    w_release = !bus.req[r_last_winner] || w_timeout;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; requests seen in RELEASE wait for IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_any_req) w_next = S_GRANT;
      S_GRANT:   if (w_release) w_next = S_RELEASE;
      S_RELEASE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Output logic: operand lane is driven only while a grant is active.
  always_comb begin
    w_avec     = 4'h0;
    w_avec_vld = 1'b0;
    w_busy     = (r_state != S_IDLE);
    if (r_state == S_GRANT) begin
      w_avec     = bus.req_avec[{r_last_winner, 2'b00} +: 4];
      w_avec_vld = 1'b1;
    end
  end

  // Grant, winner memory and hold counter; gnt is registered alongside the state.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_gnt         <= 4'h0;
      r_last_winner <= 2'd3;
      r_hold_cnt    <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt         <= 4'b0001 << w_winner;
            r_last_winner <= w_winner;
            r_hold_cnt    <= 8'h00;
          end
        end
        S_GRANT: begin
          r_hold_cnt <= r_hold_cnt + 8'h01;
          if (w_release) r_gnt <= 4'h0;
        end
        default: r_gnt <= 4'h0;
      endcase
    end
  end

  // ---- stage p0 -> p1: lane result captured one cycle after the operand ----
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_resp_q_p1   <= 4'h0;
      r_resp_vld_p1 <= 1'b0;
    end else begin
      r_resp_q_p1   <= bus.qvec;
      r_resp_vld_p1 <= w_avec_vld;
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.avec     = w_avec;
  assign bus.avec_vld = w_avec_vld;
  assign bus.resp_q   = r_resp_q_p1;
  assign bus.resp_vld = r_resp_vld_p1;
  assign bus.busy     = w_busy;

endmodule

// File: tb/tb_v_hier_sched.sv
// Testbench for v_hier_sched: table-driven basic transaction, hand-written
// corner sequences, then random traffic against a cycle-level reference model.
module tb_v_hier_sched;
  localparam int MAX_HOLD = 8;
`ifdef V_HIER_SCHED_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_l;
  v_hier_sched_if bus ();

  always #5 clk = ~clk;

  // Lane datapath stand-in: result = operand + 3.
  assign bus.qvec = bus.avec + 4'd3;

  v_hier_sched #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .reset_l (reset_l),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the lane, how long it has held it, and how many
  // dead cycles remain before arbitration may run again.
  int owner;
  int held;
  int gap;
  int last;
  logic [3:0] m_resp_q;
  logic       m_resp_vld;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_avec();
    return (owner >= 0) ? bus.req_avec[owner*4 +: 4] : 4'h0;
  endfunction

  function automatic logic [3:0] m_gnt();
    return (owner >= 0) ? 4'(1 << owner) : 4'h0;
  endfunction

  task automatic model_reset();
    owner = -1; held = 0; gap = 0; last = 3;
    m_resp_q = 4'h0; m_resp_vld = 1'b0;
  endtask

  task automatic model_step();
    m_resp_q   = m_avec() + 4'd3;
    m_resp_vld = (owner >= 0);
    if (owner >= 0) begin
      held++;
      if (!bus.req[owner] || (TO && held == MAX_HOLD)) begin
        owner = -1;
        gap   = 1;
      end
    end else if (gap > 0) begin
      gap--;
    end else if (bus.req != 4'h0) begin
      for (int k = 1; k <= 4; k++) begin
        if (owner < 0 && bus.req[(last + k) % 4]) owner = (last + k) % 4;
      end
      last = owner;
      held = 0;
    end
  endtask

  task automatic compare_model();
    chk("gnt",      bus.gnt,      m_gnt());
    chk("avec",     bus.avec,     m_avec());
    chk("avec_vld", bus.avec_vld, (owner >= 0));
    chk("resp_q",   bus.resp_q,   m_resp_q);
    chk("resp_vld", bus.resp_vld, m_resp_vld);
    chk("busy",     bus.busy,     (owner >= 0) || (gap > 0));
    chk("onehot",   ($countones(bus.gnt) <= 1), 1'b1);
  endtask

  // One clock: drive inputs, let the edge happen, compare just after it,
  // and return on the following falling edge.
  task automatic tick(input logic [3:0] r, input logic [15:0] av);
    bus.req = r;
    bus.req_avec = av;
    @(posedge clk);
    model_step();
    #1;
    compare_model();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset_l = 1'b0;
    bus.req = 4'h0;
    bus.req_avec = 16'h0;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_gnt",      bus.gnt,      4'h0);
    chk("rst_resp_q",   bus.resp_q,   4'h0);
    chk("rst_resp_vld", bus.resp_vld, 1'b0);
    chk("rst_busy",     bus.busy,     1'b0);
    chk("rst_avec_vld", bus.avec_vld, 1'b0);
    @(negedge clk);
    reset_l = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [15:0] av;
    logic [3:0]  gnt;
    logic [3:0]  avec;
    logic        vld;
    logic [3:0]  rq;
    logic        rv;
    logic        busy;
  } vec_t;

  vec_t tbl [5];

  initial begin
    logic [3:0]  rreq;
    logic [15:0] rav;
    logic [3:0]  exp_g;
    int          period;

    // Single requester 0, operand A: three GRANT cycles, one RELEASE, back to IDLE.
    tbl[0] = '{4'b0001, 16'h000A, 4'b0001, 4'hA, 1'b1, 4'h3, 1'b0, 1'b1};
    tbl[1] = '{4'b0001, 16'h000A, 4'b0001, 4'hA, 1'b1, 4'hD, 1'b1, 1'b1};
    tbl[2] = '{4'b0001, 16'h000A, 4'b0001, 4'hA, 1'b1, 4'hD, 1'b1, 1'b1};
    tbl[3] = '{4'b0000, 16'h000A, 4'b0000, 4'h0, 1'b0, 4'hD, 1'b1, 1'b1};
    tbl[4] = '{4'b0000, 16'h0000, 4'b0000, 4'h0, 1'b0, 4'h3, 1'b0, 1'b0};

    reset_l = 1'b0;
    bus.req = 4'h0;
    bus.req_avec = 16'h0;
    model_reset();
    @(negedge clk);
    apply_reset();

    for (int i = 0; i < 5; i++) begin
      tick(tbl[i].req, tbl[i].av);
      chk("tbl_gnt",      bus.gnt,      tbl[i].gnt);
      chk("tbl_avec",     bus.avec,     tbl[i].avec);
      chk("tbl_avec_vld", bus.avec_vld, tbl[i].vld);
      chk("tbl_resp_q",   bus.resp_q,   tbl[i].rq);
      chk("tbl_resp_vld", bus.resp_vld, tbl[i].rv);
      chk("tbl_busy",     bus.busy,     tbl[i].busy);
    end

    // Wrap-around: 3 wins, then 0; with all requesting next, 1 follows 0.
    apply_reset();
    tick(4'b1000, 16'h5000); chk("wrap_g3", bus.gnt, 4'b1000);
    tick(4'b0000, 16'h0);
    tick(4'b0001, 16'h0007); chk("wrap_idle", bus.gnt, 4'b0000);
    tick(4'b0001, 16'h0007); chk("wrap_g0", bus.gnt, 4'b0001);
    tick(4'b0000, 16'h0);
    tick(4'b0000, 16'h0);
    tick(4'b1111, 16'h4321); chk("wrap_next_g1", bus.gnt, 4'b0010);
    tick(4'b0000, 16'h0);
    tick(4'b0000, 16'h0);

    // Request arriving during RELEASE is not granted until after IDLE.
    tick(4'b0001, 16'h0);    chk("rel_g0", bus.gnt, 4'b0001);
    tick(4'b0100, 16'h0B00); chk("rel_release", bus.gnt, 4'b0000);
    tick(4'b0100, 16'h0B00); chk("rel_idle", bus.gnt, 4'b0000);
    tick(4'b0100, 16'h0B00); chk("rel_g2", bus.gnt, 4'b0100);
    chk("rel_avec", bus.avec, 4'hB);
    tick(4'b0000, 16'h0);
    tick(4'b0000, 16'h0);

    // Asynchronous reset in the middle of a grant.
    apply_reset();
    tick(4'b0001, 16'h0006); chk("ar_g0", bus.gnt, 4'b0001);
    tick(4'b0001, 16'h0006); chk("ar_rv", bus.resp_vld, 1'b1);
    #2;
    reset_l = 1'b0;
    model_reset();
    #1;
    chk("ar_gnt",      bus.gnt,      4'h0);
    chk("ar_avec_vld", bus.avec_vld, 1'b0);
    chk("ar_resp_vld", bus.resp_vld, 1'b0);
    chk("ar_busy",     bus.busy,     1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_l = 1'b1;
    tick(4'b0110, 16'h0);    chk("ar_first_g1", bus.gnt, 4'b0010);
    tick(4'b0000, 16'h0);
    tick(4'b0000, 16'h0);

    // All four requesting continuously. With the timeout each grant lasts
    // MAX_HOLD cycles followed by RELEASE and IDLE; without it requester 0 keeps the lane.
    apply_reset();
    period = MAX_HOLD + 2;
    for (int i = 0; i < 5 * period; i++) begin
      tick(4'b1111, 16'h9876);
      if (TO) exp_g = ((i % period) < MAX_HOLD) ? 4'(1 << ((i / period) % 4)) : 4'h0;
      else    exp_g = 4'b0001;
      chk("hold_gnt", bus.gnt, exp_g);
      if (!TO) chk("hold_busy", bus.busy, 1'b1);
    end
    tick(4'b0000, 16'h0);
    tick(4'b0000, 16'h0);
    tick(4'b0000, 16'h0);

    // Random traffic: requests change occasionally so grants of varied length occur.
    apply_reset();
    rreq = 4'h0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) rreq = 4'($urandom_range(0, 15));
      rav = 16'($urandom);
      tick(rreq, rav);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
